// File: rtl/rr_arbiter4_if.sv
// -----------------------------------------------------------------------------
// rr_arbiter4_if
//   Request/grant bundle between four clients and the round-robin arbiter.
//
//   Signals:
//     req         [3:0]  request vector, bit i = client i wants the resource
//     grant       [3:0]  one-hot grant, all-zero when idle
//     grant_valid        high whenever any grant bit is high
//     grant_id    [1:0]  index of the granted client (holds while idle)
//     preempt            one-cycle pulse after a timeout release
//
//   Modports:
//     master  client side: drives req, observes the grant outputs
//     slave   arbiter side: samples req, drives the grant outputs
// -----------------------------------------------------------------------------
interface rr_arbiter4_if;
  logic [3:0] req;
  logic [3:0] grant;
  logic       grant_valid;
  logic [1:0] grant_id;
  logic       preempt;

  modport master (
    output req,
    input  grant,
    input  grant_valid,
    input  grant_id,
    input  preempt
  );

  modport slave (
    input  req,
    output grant,
    output grant_valid,
    output grant_id,
    output preempt
  );
endinterface

// File: rtl/rr_arbiter4.sv
// -----------------------------------------------------------------------------
// rr_arbiter4
//   Four-requester round-robin arbiter with a bounded grant-hold timer.
//   A rotating priority pointer (last owner gets lowest priority) provides
//   fairness; a hold counter forces re-arbitration after MAX_HOLD cycles so
//   no client can keep the resource indefinitely. All outputs are registered.
//
//   Parameters:
//     MAX_HOLD  maximum consecutive grant cycles before forced re-arbitration
//               (legal range 1..255)
//
//   Ports:
//     clock  rising-edge system clock
//     reset  asynchronous, active-high reset
//     bus    rr_arbiter4_if.slave (req in; grant, grant_valid, grant_id,
//            preempt out)
// -----------------------------------------------------------------------------
module rr_arbiter4 #(
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic            clock,
  input  logic            reset,
  rr_arbiter4_if.slave    bus
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  // Result of one priority search.
  typedef struct packed {
    logic       found;
    logic [1:0] idx;
  } pick_t;

  // Counter value on the last permitted cycle of a grant.
  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

  // Scan req cyclically starting one past 'last'; the first set bit wins.
  // The final candidate (k=4) wraps back to 'last' itself, so the previous
  // owner is only chosen when nobody else is asking.
  function automatic pick_t rr_pick(input logic [3:0] req, input logic [1:0] last);
    pick_t      p;
    logic [1:0] cand;
    p = '0;
    for (int k = 1; k <= 4; k++) begin
      cand = last + 2'(k);
      if (!p.found && req[cand]) begin
        p.found = 1'b1;
        p.idx   = cand;
      end
    end
    return p;
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_t     state_q,  state_d;
  logic [1:0] id_q,     id_d;      // current owner; doubles as grant_id
  logic [1:0] last_q,   last_d;    // most recent owner (lowest priority)
  logic [7:0] cnt_q,    cnt_d;     // cycles held minus one
  logic [3:0] grant_q,  grant_d;
  logic       valid_q,  valid_d;
  logic       pre_q,    pre_d;

  pick_t      pick_idle;
  pick_t      pick_hand;
  logic       owner_req;
  logic       drop;
  logic       timeout;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values of its neighbours; blocking here would create
  // order-dependent simulation and mismatch synthesis.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      id_q    <= 2'd0;
      last_q  <= 2'd3;   // first arbitration after reset favours client 0
      cnt_q   <= 8'd0;
      grant_q <= 4'b0000;
      valid_q <= 1'b0;
      pre_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      grant_q <= grant_d;
      valid_q <= valid_d;
      pre_q   <= pre_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Release detection
  // ---------------------------------------------------------------------------
  assign owner_req = bus.req[id_q];
  assign drop      = !owner_req;
  // A coincident drop wins over timeout, so timeout requires req still high.
  assign timeout   = owner_req && (cnt_q == HOLD_LAST);

  // Idle search uses the stored pointer; handoff search treats the outgoing
  // owner as the new 'last' so it drops to lowest priority.
  assign pick_idle = rr_pick(bus.req, last_q);
  assign pick_hand = rr_pick(bus.req, id_q);

  // ---------------------------------------------------------------------------
  // Next-state / output logic
  // ---------------------------------------------------------------------------
  // NOTE: every variable gets a default at the top of the block; any path that
  // left one unassigned would infer a latch.
  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    grant_d = grant_q;
    valid_d = valid_q;
    pre_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (pick_idle.found) begin
          state_d = GRANT;
          id_d    = pick_idle.idx;
          cnt_d   = 8'd0;
          grant_d = 4'b0001 << pick_idle.idx;
          valid_d = 1'b1;
        end else begin
          grant_d = 4'b0000;
          valid_d = 1'b0;
        end
      end

      GRANT: begin
        if (drop || timeout) begin
          last_d = id_q;
          pre_d  = timeout;
          // Handoff on the same edge: no idle cycle between owners.
          if (pick_hand.found) begin
            id_d    = pick_hand.idx;
            cnt_d   = 8'd0;
            grant_d = 4'b0001 << pick_hand.idx;
            valid_d = 1'b1;
          end else begin
            state_d = IDLE;
            cnt_d   = 8'd0;
            grant_d = 4'b0000;
            valid_d = 1'b0;
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      default: begin
        state_d = IDLE;
        grant_d = 4'b0000;
        valid_d = 1'b0;
      end
    endcase
  end

  assign bus.grant       = grant_q;
  assign bus.grant_valid = valid_q;
  assign bus.grant_id    = id_q;
  assign bus.preempt     = pre_q;

  // ---------------------------------------------------------------------------
  // Structural invariants
  // ---------------------------------------------------------------------------
  a_grant_onehot0 : assert property (
    @(posedge clock) disable iff (reset) $onehot0(grant_q)
  );

  a_valid_matches : assert property (
    @(posedge clock) disable iff (reset) valid_q == (|grant_q)
  );

  a_id_matches : assert property (
    @(posedge clock) disable iff (reset) valid_q |-> grant_q[id_q]
  );

  a_preempt_with_grant : assert property (
    @(posedge clock) disable iff (reset) pre_q |-> valid_q
  );

endmodule
